// File: rtl/ysyx_23060236_defs.sv
// rtl/ysyx_23060236_defs.sv - shared GPR constants and writeback source encoding
package ysyx_23060236_defs;

  localparam int GPR_NUM   = 16;
  localparam int GPR_AW    = 4;
  localparam int GPR_DW    = 32;
  localparam int GPR_CNT_W = 2;

  typedef enum logic {
    WB_EXU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/ysyx_23060236_rr_arb2.sv
// rtl/ysyx_23060236_rr_arb2.sv - 2-way round-robin arbiter, one grant per cycle
module ysyx_23060236_rr_arb2
  import ysyx_23060236_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr;

  // The pointer only moves on contention, so a lone requester never steals the other's turn.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == WB_EXU) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= WB_EXU;
    end else if (req == 2'b11) begin
      ptr <= (ptr == WB_EXU) ? WB_LSU : WB_EXU;
    end
  end

endmodule

// File: rtl/ysyx_23060236_rf_scoreboard.sv
// rtl/ysyx_23060236_rf_scoreboard.sv - register-file write scoreboard and writeback sequencer
module ysyx_23060236_rf_scoreboard
  import ysyx_23060236_defs::*;
#(
  parameter int ADDR_WIDTH = GPR_AW,
  parameter int DATA_WIDTH = GPR_DW,
  parameter int CNT_WIDTH  = GPR_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  input  logic                  issue_use1,
  input  logic                  issue_use2,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  issue_rdwen,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_WIDTH-1:0] wb0_rd,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_WIDTH-1:0] wb1_rd,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  rf_wen,
  output logic                  rf_valid,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  busy,
  output logic                  err
);

  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt [NREG];
  logic [NREG-1:0]      inc_vec;
  logic [NREG-1:0]      dec_vec;
  logic [1:0]           gnt;
  logic                 hazard;
  logic                 issue_fire;
  logic                 retire;

  always_comb begin
    hazard = (issue_use1 && issue_rs1 != '0 && cnt[issue_rs1] != '0) ||
             (issue_use2 && issue_rs2 != '0 && cnt[issue_rs2] != '0) ||
             (issue_rdwen && issue_rd != '0 && cnt[issue_rd] == CNT_MAX);
  end

  assign issue_ready = ~hazard;
  assign issue_fire  = issue_valid & issue_ready;
  assign retire      = rf_valid & rf_wen;

  // Entry 0 is never tracked; its inc/dec bits stay low.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    busy    = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      inc_vec[i] = issue_fire && issue_rdwen && (issue_rd == ADDR_WIDTH'(i));
      dec_vec[i] = retire && (rf_waddr == ADDR_WIDTH'(i)) && (cnt[i] != '0);
      busy       = busy | (cnt[i] != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        cnt[i] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (retire && cnt[rf_waddr] == '0) begin
        err <= 1'b1;
      end
    end
  end

  ysyx_23060236_rr_arb2 u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({wb1_valid, wb0_valid}),
    .gnt   (gnt)
  );

  assign wb0_ready = gnt[0];
  assign wb1_ready = gnt[1];

  // Registered write port: grant in cycle N drives the RF in N+1.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_valid <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt[1]) begin
      rf_valid <= 1'b1;
      rf_wen   <= (wb1_rd != '0);
      rf_waddr <= wb1_rd;
      rf_wdata <= wb1_data;
    end else if (gnt[0]) begin
      rf_valid <= 1'b1;
      rf_wen   <= (wb0_rd != '0);
      rf_waddr <= wb0_rd;
      rf_wdata <= wb0_data;
    end else begin
      rf_valid <= 1'b0;
      rf_wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_rf_scoreboard.sv
// tb/tb_ysyx_23060236_rf_scoreboard.sv - directed self-checking bench for the rf scoreboard
module tb_ysyx_23060236_rf_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, issue_use1, issue_use2, issue_rdwen;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [3:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic        rf_wen, rf_valid, busy, err;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ysyx_23060236_rf_scoreboard dut (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_use1  (issue_use1),
    .issue_use2  (issue_use2),
    .issue_rd    (issue_rd),
    .issue_rdwen (issue_rdwen),
    .wb0_valid   (wb0_valid),
    .wb0_ready   (wb0_ready),
    .wb0_rd      (wb0_rd),
    .wb0_data    (wb0_data),
    .wb1_valid   (wb1_valid),
    .wb1_ready   (wb1_ready),
    .wb1_rd      (wb1_rd),
    .wb1_data    (wb1_data),
    .rf_wen      (rf_wen),
    .rf_valid    (rf_valid),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err         (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_use1 = 0; issue_use2 = 0; issue_rdwen = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
    wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic issue_one(input logic [3:0] rd);
    issue_valid = 1; issue_rdwen = 1; issue_rd = rd;
    tick();
    issue_valid = 0; issue_rdwen = 0; issue_rd = 0;
  endtask

  initial begin
    // 1 reset state
    do_reset();
    #1;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_valid", rf_valid, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    issue_use1 = 1; issue_rs1 = 5; issue_use2 = 1; issue_rs2 = 15; issue_rdwen = 1; issue_rd = 7;
    #1;
    check("rst_issue_ready", issue_ready, 1);
    idle_inputs();

    // 2 RAW hazard and retire latency
    issue_one(4'd5);
    check("raw_busy", busy, 1);
    issue_use1 = 1; issue_rs1 = 5;
    #1;
    check("raw_stall", issue_ready, 0);
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'h1234;
    #1;
    check("raw_wb0_ready", wb0_ready, 1);
    tick();
    wb0_valid = 0;
    check("raw_rf_wen", rf_wen, 1);
    check("raw_rf_waddr", rf_waddr, 5);
    check("raw_rf_wdata", rf_wdata, 32'h1234);
    check("raw_no_bypass", issue_ready, 0);
    tick();
    check("raw_ready_after", issue_ready, 1);
    check("raw_busy_clear", busy, 0);
    check("raw_rf_valid_drop", rf_valid, 0);
    check("raw_rf_wdata_hold", rf_wdata, 32'h1234);
    check("raw_err", err, 0);
    idle_inputs();

    // 3 conflict: both sources valid together
    do_reset();
    issue_one(4'd3);
    issue_one(4'd4);
    wb0_valid = 1; wb0_rd = 3; wb0_data = 32'hAAAA_0003;
    wb1_valid = 1; wb1_rd = 4; wb1_data = 32'hBBBB_0004;
    #1;
    check("conf_gnt0_first", {wb1_ready, wb0_ready}, 2'b01);
    tick();
    wb0_valid = 0;
    check("conf_waddr_3", rf_waddr, 3);
    check("conf_wdata_3", rf_wdata, 32'hAAAA_0003);
    check("conf_gnt1_next", {wb1_ready, wb0_ready}, 2'b10);
    tick();
    wb1_valid = 0;
    check("conf_waddr_4", rf_waddr, 4);
    check("conf_wdata_4", rf_wdata, 32'hBBBB_0004);
    check("conf_wen_4", rf_wen, 1);
    tick();
    check("conf_busy", busy, 0);
    check("conf_err", err, 0);
    // pointer now favours wb1 on the next contention
    wb0_valid = 1; wb0_rd = 0; wb1_valid = 1; wb1_rd = 0;
    #1;
    check("conf_ptr_flipped", {wb1_ready, wb0_ready}, 2'b10);
    idle_inputs();

    // 4 saturation at CNT max
    do_reset();
    check("sat_ptr_reset", wb0_ready, 0);
    wb0_valid = 1; wb1_valid = 1;
    #1;
    check("sat_ptr_reset_gnt", {wb1_ready, wb0_ready}, 2'b01);
    idle_inputs();
    do_reset();
    issue_one(4'd7);
    issue_one(4'd7);
    issue_one(4'd7);
    issue_rdwen = 1; issue_rd = 7;
    #1;
    check("sat_stall", issue_ready, 0);
    wb0_valid = 1; wb0_rd = 7; wb0_data = 32'h77;
    tick();
    wb0_valid = 0;
    check("sat_still_stall", issue_ready, 0);
    tick();
    check("sat_released", issue_ready, 1);
    issue_rdwen = 0; issue_rd = 0;

    // 5 x0 writeback and err
    wb1_valid = 1; wb1_rd = 0; wb1_data = 32'hDEAD;
    #1;
    check("x0_wb1_ready", wb1_ready, 1);
    tick();
    wb1_valid = 0;
    check("x0_rf_valid", rf_valid, 1);
    check("x0_rf_wen", rf_wen, 0);
    check("x0_busy", busy, 1);
    wb0_valid = 1; wb0_rd = 9; wb0_data = 32'h99;
    tick();
    wb0_valid = 0;
    check("x0_err_before", err, 0);
    tick();
    check("err_set", err, 1);
    tick();
    tick();
    check("err_sticky", err, 1);
    check("err_busy_kept", busy, 1);

    // 6 simultaneous inc and dec on x2
    do_reset();
    check("sim_err_cleared", err, 0);
    issue_one(4'd2);
    wb0_valid = 1; wb0_rd = 2; wb0_data = 32'h22;
    tick();
    wb0_valid = 0;
    issue_valid = 1; issue_rdwen = 1; issue_rd = 2;
    #1;
    check("sim_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 0; issue_rdwen = 0;
    check("sim_busy", busy, 1);
    check("sim_err", err, 0);
    wb0_valid = 1; wb0_rd = 2;
    tick();
    wb0_valid = 0;
    tick();
    check("sim_count_was_1_busy", busy, 0);
    check("sim_count_was_1_err", err, 0);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
